// File: rtl/pio_in_debounce_pkg.sv
// rtl/pio_in_debounce_pkg.sv - shared types and default constants for the PIO input debouncer
// Contents:
//   db_state_e           per-bit qualification state {STABLE, SETTLING}
//   PIO_IN_WIDTH         default number of input bits (PIO in_port width)
//   DEBOUNCE_1MS_50MHZ   default settle time in clocks (1 ms at 50 MHz)
//   SYNC_STAGES_DEFAULT  default synchronizer depth
package pio_in_debounce_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } db_state_e;

  localparam int PIO_IN_WIDTH        = 10;
  localparam int DEBOUNCE_1MS_50MHZ  = 50000;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/pio_in_debounce_bit.sv
// rtl/pio_in_debounce_bit.sv - one-bit synchronizer, settle counter and edge pulse generator
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   raw_in   in   raw asynchronous level
//   level    out  debounced level (registered)
//   rise     out  one-cycle pulse on an accepted 0->1 change (registered)
//   fall     out  one-cycle pulse on an accepted 1->0 change (registered)
module debounce_bit
  import pio_in_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  db_state_e              r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  // Pulses default low every cycle so they last exactly one clock.
  // Any return of the synchronized level to the accepted level while
  // settling drops back to STABLE, so the next departure restarts at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE: begin
          if (w_sync != r_level) begin
            r_state <= SETTLING;
            r_cnt   <= '0;
          end
        end
        SETTLING: begin
          if (w_sync == r_level) begin
            r_state <= STABLE;
          end else if (r_cnt == CNT_LAST) begin
            r_level <= w_sync;
            r_rise  <= w_sync;
            r_fall  <= ~w_sync;
            r_state <= STABLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= STABLE;
      endcase
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/pio_in_debounce.sv
// rtl/pio_in_debounce.sv - synchronize and debounce switch levels feeding the Avalon input PIO
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   raw_in   in   [WIDTH] raw asynchronous switch levels
//   sw_out   out  [WIDTH] debounced levels to PIO in_port
//   rise     out  [WIDTH] per-bit accepted 0->1 pulse
//   fall     out  [WIDTH] per-bit accepted 1->0 pulse
//   changed  out  OR of all rise and fall bits
module pio_in_debounce
  import pio_in_debounce_pkg::*;
#(
  parameter int WIDTH           = PIO_IN_WIDTH,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_in  (raw_in[g]),
      .level   (w_level[g]),
      .rise    (w_rise[g]),
      .fall    (w_fall[g])
    );
  end

  assign sw_out  = w_level;
  assign rise    = w_rise;
  assign fall    = w_fall;
  // Built only from pulse flops, so it carries no path from raw_in.
  assign changed = |(w_rise | w_fall);

endmodule
